// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store sequencer between a CPU request port and a
//               single-cycle data memory. It accepts one request at a time,
//               checks natural alignment, drives one memory access cycle and
//               returns the result through a valid/ready response port.
//               A misaligned request bypasses memory and returns a fault
//               response. fault_cnt counts faults and saturates at 255.
// Ports       : clk, rst_n (async, active low)
//               req_*      : CPU request (valid/ready, we, size, signed,
//                            addr, wdata)
//               resp_*     : response (valid/ready, rdata, misalign)
//               fault_cnt  : saturating misalignment counter
//               MemR, MemWr, MemWrBits, MemRBits, addr, data : memory side
//               ReadData   : combinational read data from memory
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter logic [2:0] MEMR_LW  = 3'b000,
  parameter logic [2:0] MEMR_LHU = 3'b001,
  parameter logic [2:0] MEMR_LH  = 3'b010,
  parameter logic [2:0] MEMR_LBU = 3'b011,
  parameter logic [2:0] MEMR_LB  = 3'b100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic [7:0]  fault_cnt,
  output logic        MemR,
  output logic        MemWr,
  output logic [1:0]  MemWrBits,
  output logic [2:0]  MemRBits,
  output logic [31:0] addr,
  output logic [31:0] data,
  input  logic [31:0] ReadData
);

  localparam logic [1:0] C_SZ_HALF = 2'b01;
  localparam logic [1:0] C_SZ_BYTE = 2'b10;
  localparam logic [1:0] C_WR_WORD = 2'b00;
  localparam logic [1:0] C_WR_HALF = 2'b01;
  localparam logic [1:0] C_WR_BYTE = 2'b10;
  localparam logic [7:0] C_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_we;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_fault_cnt;

  logic        w_accept;
  logic        w_aligned;
  logic [1:0]  w_wr_bits;
  logic [2:0]  w_rd_bits;

  // Alignment of the incoming request; size 11 is handled as a word.
  always_comb begin
    w_aligned = 1'b1;
    case (req_size)
      C_SZ_HALF: w_aligned = ~req_addr[0];
      C_SZ_BYTE: w_aligned = 1'b1;
      default:   w_aligned = (req_addr[1:0] == 2'b00);
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // Width/extension codes for the latched request.
  always_comb begin
    w_wr_bits = C_WR_WORD;
    w_rd_bits = MEMR_LW;
    case (r_size)
      C_SZ_HALF: begin
        w_wr_bits = C_WR_HALF;
        w_rd_bits = r_signed ? MEMR_LH : MEMR_LHU;
      end
      C_SZ_BYTE: begin
        w_wr_bits = C_WR_BYTE;
        w_rd_bits = r_signed ? MEMR_LB : MEMR_LBU;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs. Memory strobes come straight from
  // the state register so an asynchronous reset removes them at once.
  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_misalign = 1'b0;
    MemR          = 1'b0;
    MemWr         = 1'b0;
    MemWrBits     = 2'b00;
    MemRBits      = 3'b000;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = w_aligned ? S_ACCESS : S_FAULT;
        end
      end
      S_ACCESS: begin
        MemR  = ~r_we;
        MemWr = r_we;
        if (r_we) begin
          MemWrBits = w_wr_bits;
        end else begin
          MemRBits = w_rd_bits;
        end
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        resp_valid    = 1'b1;
        resp_misalign = 1'b1;
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, result capture and fault counting. resp_rdata is
  // cleared on acceptance so a fault response always reports zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_fault_cnt <= 8'h00;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_signed <= req_signed;
      r_size   <= req_size;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_rdata  <= 32'h0;
      if (!w_aligned && (r_fault_cnt != C_CNT_MAX)) begin
        r_fault_cnt <= r_fault_cnt + 8'd1;
      end
    end else if (r_state == S_ACCESS) begin
      r_rdata <= r_we ? 32'h0 : ReadData;
    end
  end

  assign resp_rdata = r_rdata;
  assign fault_cnt  = r_fault_cnt;
  assign addr       = r_addr;
  assign data       = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Contains a byte-wide
//               data memory that obeys MemWrBits/MemRBits, a transaction-level
//               reference model (word array plus request timing), a per-cycle
//               compare process and directed stimulus with literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam logic [2:0] C_LW  = 3'b000;
  localparam logic [2:0] C_LHU = 3'b001;
  localparam logic [2:0] C_LH  = 3'b010;
  localparam logic [2:0] C_LBU = 3'b011;
  localparam logic [2:0] C_LB  = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic [7:0]  fault_cnt;
  logic        MemR;
  logic        MemWr;
  logic [1:0]  MemWrBits;
  logic [2:0]  MemRBits;
  logic [31:0] addr;
  logic [31:0] data;
  logic [31:0] ReadData;

  int n_checks = 0;
  int n_err    = 0;

  mem_access_unit #(
    .MEMR_LW (C_LW),
    .MEMR_LHU(C_LHU),
    .MEMR_LH (C_LH),
    .MEMR_LBU(C_LBU),
    .MEMR_LB (C_LB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_misalign(resp_misalign),
    .fault_cnt    (fault_cnt),
    .MemR         (MemR),
    .MemWr        (MemWr),
    .MemWrBits    (MemWrBits),
    .MemRBits     (MemRBits),
    .addr         (addr),
    .data         (data),
    .ReadData     (ReadData)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- data memory environment (256 bytes) ----------------
  logic [7:0] emem [0:255];
  logic [7:0] ea;
  assign ea = addr[7:0];

  always_comb begin
    ReadData = 32'h0;
    case (MemRBits)
      C_LW:  ReadData = {emem[{ea[7:2], 2'b11}], emem[{ea[7:2], 2'b10}],
                         emem[{ea[7:2], 2'b01}], emem[{ea[7:2], 2'b00}]};
      C_LHU: ReadData = {16'h0, emem[{ea[7:1], 1'b1}], emem[{ea[7:1], 1'b0}]};
      C_LH:  ReadData = {{16{emem[{ea[7:1], 1'b1}][7]}},
                         emem[{ea[7:1], 1'b1}], emem[{ea[7:1], 1'b0}]};
      C_LBU: ReadData = {24'h0, emem[ea]};
      C_LB:  ReadData = {{24{emem[ea][7]}}, emem[ea]};
      default: ReadData = 32'h0;
    endcase
  end

  initial begin
    for (int i = 0; i < 256; i++) emem[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (MemWr) begin
        case (MemWrBits)
          2'b00: for (int k = 0; k < 4; k++) emem[{ea[7:2], 2'b00} + 8'(k)] = data[8*k +: 8];
          2'b01: begin
            emem[{ea[7:1], 1'b0}] = data[7:0];
            emem[{ea[7:1], 1'b1}] = data[15:8];
          end
          2'b10: emem[ea] = data[7:0];
          default: ;
        endcase
      end
    end
  end

  // Strobe activity, counted once per cycle.
  int nwr = 0;
  int nrd = 0;
  initial forever begin
    @(negedge clk);
    if (MemWr) nwr++;
    if (MemR)  nrd++;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_w [0:63];

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
  endfunction

  function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (int'(a[7:0]) % size_bytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] v;
    int nb;
    w  = ref_w[a[7:2]];
    nb = size_bytes(sz);
    if (nb == 4) return w;
    v = (w >> (8 * int'(a[1:0]))) & ((32'h1 << (8 * nb)) - 32'h1);
    if (sg && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
    return v;
  endfunction

  function automatic logic [2:0] rd_code(input logic [1:0] sz, input logic sg);
    if (size_bytes(sz) == 2) return sg ? C_LH : C_LHU;
    if (size_bytes(sz) == 1) return sg ? C_LB : C_LBU;
    return C_LW;
  endfunction

  function automatic logic [1:0] wr_code(input logic [1:0] sz);
    return (size_bytes(sz) == 2) ? 2'b01 : (size_bytes(sz) == 1) ? 2'b10 : 2'b00;
  endfunction

  int          m_edge  = 0;
  logic        m_busy  = 1'b0;
  int          m_acc   = 0;
  logic        m_mis   = 1'b0;
  logic        m_we    = 1'b0;
  logic [1:0]  m_size  = 2'b00;
  logic        m_sg    = 1'b0;
  logic [31:0] m_addr  = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_load  = 32'h0;
  int          m_fault = 0;

  // A request accepted at edge A is in its memory cycle until edge A+1
  // (aligned), then responds until a resp_ready edge; a fault responds
  // straight after A. Stores take effect at the edge that ends the access.
  initial begin
    for (int i = 0; i < 64; i++) ref_w[i] = 32'h0;
    forever begin
      @(posedge clk);
      m_edge = m_edge + 1;
      if (!rst_n) begin
        m_busy  = 1'b0;
        m_fault = 0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
      end else if (m_busy) begin
        if (!m_mis && m_edge == m_acc + 1) begin
          if (m_we) begin
            logic [31:0] msk;
            int sh;
            sh  = (size_bytes(m_size) == 4) ? 0 : 8 * int'(m_addr[1:0]);
            msk = (size_bytes(m_size) == 4) ? 32'hFFFFFFFF
                : (((32'h1 << (8 * size_bytes(m_size))) - 32'h1) << sh);
            ref_w[m_addr[7:2]] = (ref_w[m_addr[7:2]] & ~msk) | ((m_wdata << sh) & msk);
          end
        end else if (resp_ready) begin
          m_busy = 1'b0;
        end
      end else if (req_valid) begin
        m_busy  = 1'b1;
        m_acc   = m_edge;
        m_we    = req_we;
        m_size  = req_size;
        m_sg    = req_signed;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_mis   = is_mis(req_size, req_addr);
        if (m_mis) begin
          if (m_fault < 255) m_fault++;
        end else if (!req_we) begin
          m_load = ref_load(req_size, req_signed, req_addr);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic in_acc;
    logic rsp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_misalign", resp_misalign, 0);
        chk("rst_strobes", {MemR, MemWr, MemWrBits, MemRBits}, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_fault_cnt", fault_cnt, 0);
        chk("rst_addr_data", addr | data, 0);
      end else begin
        in_acc = m_busy && !m_mis && (m_edge == m_acc);
        rsp    = m_busy && (m_edge >= m_acc + (m_mis ? 0 : 1));
        chk("req_ready", req_ready, !m_busy);
        chk("resp_valid", resp_valid, rsp);
        chk("resp_misalign", resp_misalign, rsp && m_mis);
        chk("MemR", MemR, in_acc && !m_we);
        chk("MemWr", MemWr, in_acc && m_we);
        chk("MemWrBits", MemWrBits, (in_acc && m_we) ? wr_code(m_size) : 2'b00);
        chk("MemRBits", MemRBits, (in_acc && !m_we) ? rd_code(m_size, m_sg) : 3'b000);
        chk("addr", addr, m_addr);
        chk("data", data, m_wdata);
        chk("fault_cnt", fault_cnt, m_fault);
        if (rsp) chk("resp_rdata", resp_rdata, (m_mis || m_we) ? 32'h0 : m_load);
      end
    end
  end

  // ---------------- driver helpers ----------------
  // Called just after a negedge; returns just after the accepting posedge.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, output int acc);
    logic rdy;
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc = m_edge;
        break;
      end
    end
    req_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_resp(output logic [31:0] rd, output logic mis, output int seen);
    seen = -1;
    rd   = 32'h0;
    mis  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd   = resp_rdata;
        mis  = resp_misalign;
        seen = m_edge;
        break;
      end
    end
    if (seen < 0) chk("resp_timeout", 0, 1);
  endtask

  // Full transaction with resp_ready high; strb holds {MemR,MemWr,MemWrBits,
  // MemRBits} as seen in the cycle after acceptance; lat is edges from
  // acceptance to the first cycle with resp_valid.
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic mis, output int lat,
                      output logic [6:0] strb);
    int acc;
    int seen;
    @(negedge clk); #1;
    do_req(we, sz, sg, a, wd, acc);
    strb = {MemR, MemWr, MemWrBits, MemRBits};
    wait_resp(rd, mis, seen);
    lat = seen - acc;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        mis;
    int          lat;
    logic [6:0]  strb;
    int          w0;
    int          r0;
    int          acc;
    int          seen;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    #2;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_fault_cnt", fault_cnt, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // sw 0x10 / lw 0x10
    w0 = nwr;
    xact(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, rd, mis, lat, strb);
    chk("sw_strobe", strb, 7'b01_00_000);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_latency", lat, 1);
    chk("sw_one_write", nwr - w0, 1);
    xact(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, mis, lat, strb);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_latency", lat, 1);

    // sb 0x13 0x80 / lb / lbu
    xact(1'b1, 2'b10, 1'b0, 32'h13, 32'h00000080, rd, mis, lat, strb);
    chk("sb_strobe", strb, 7'b01_10_000);
    xact(1'b0, 2'b10, 1'b1, 32'h13, 32'h0, rd, mis, lat, strb);
    chk("lb_rbits", strb[2:0], 3'b100);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    xact(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd, mis, lat, strb);
    chk("lbu_rbits", strb[2:0], 3'b011);
    chk("lbu_rdata", rd, 32'h00000080);

    // sh 0x12 0x8001 -> word 0x8001BEEF; lh / lhu
    xact(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, rd, mis, lat, strb);
    chk("sh_strobe", strb, 7'b01_01_000);
    xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, mis, lat, strb);
    chk("lh_rdata", rd, 32'hFFFF8001);
    xact(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, mis, lat, strb);
    chk("lhu_rdata", rd, 32'h00008001);

    // misaligned lw 0x02 and sh 0x05
    w0 = nwr; r0 = nrd;
    xact(1'b0, 2'b00, 1'b0, 32'h02, 32'h0, rd, mis, lat, strb);
    chk("lw_mis_flag", mis, 1);
    chk("lw_mis_latency", lat, 0);
    chk("lw_mis_rdata", rd, 32'h0);
    xact(1'b1, 2'b01, 1'b0, 32'h05, 32'h1234, rd, mis, lat, strb);
    chk("sh_mis_flag", mis, 1);
    chk("mis_fault_cnt", fault_cnt, 2);
    chk("mis_no_strobes", (nwr - w0) + (nrd - r0), 0);

    // size 11 behaves as word
    xact(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, mis, lat, strb);
    chk("sz3_rdata", rd, 32'h8001BEEF);
    xact(1'b0, 2'b11, 1'b0, 32'h21, 32'h0, rd, mis, lat, strb);
    chk("sz3_mis_flag", mis, 1);

    // back-pressure: resp_ready low for 5 cycles, next request queued
    @(negedge clk); #1;
    resp_ready = 1'b0;
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, acc);
    wait_resp(rd, mis, seen);
    chk("stall_first", rd, 32'h8001BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", resp_valid, 1);
      chk("stall_rdata", resp_rdata, 32'h8001BEEF);
      chk("stall_req_ready", req_ready, 0);
    end
    #1;
    resp_ready = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, acc);
    chk("next_accept_edge", acc, seen + 7);
    wait_resp(rd, mis, seen);
    chk("lbu_after_stall", rd, 32'h000000BE);

    // reset in the middle of a store access
    @(negedge clk); #1;
    do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'h11223344, acc);
    chk("abort_wr_before", MemWr, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_wr_drop", MemWr, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("abort_mem_word", {emem[8'h13], emem[8'h12], emem[8'h11], emem[8'h10]}, 32'h8001BEEF);
    chk("abort_fault_cnt", fault_cnt, 0);
    xact(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, mis, lat, strb);
    chk("abort_load", rd, 32'h8001BEEF);

    // fault counter saturation
    for (int i = 0; i < 300; i++) begin
      xact(1'b0, 2'b00, 1'b0, 32'h01, 32'h0, rd, mis, lat, strb);
    end
    @(negedge clk);
    chk("fault_saturate", fault_cnt, 255);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEMR_LW, default 3'b000, MemRBits code for a word load.
REQ-002 SHALL have parameter MEMR_LHU, default 3'b001, MemRBits code for an unsigned half load.
REQ-003 SHALL have parameter MEMR_LH, default 3'b010, MemRBits code for a signed half load.
REQ-004 SHALL have parameter MEMR_LBU, default 3'b011, MemRBits code for an unsigned byte load.
REQ-005 SHALL have parameter MEMR_LB, default 3'b100, MemRBits code for a signed byte load.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have ports req_valid (input, 1) and req_ready (output, 1), the CPU-side request handshake.
REQ-009 SHALL have port req_we, input, 1 bit: 1 selects store, 0 selects load.
REQ-010 SHALL have port req_size, input, 2 bits: 00 word, 01 half, 10 byte; 11 is treated as word.
REQ-011 SHALL have port req_signed, input, 1 bit: sign-extend half/byte loads.
REQ-012 SHALL have ports req_addr (input, 32, byte address) and req_wdata (input, 32, store data in the low bits).
REQ-013 SHALL have ports resp_valid (output, 1) and resp_ready (input, 1), the response handshake.
REQ-014 SHALL have ports resp_rdata (output, 32, load result) and resp_misalign (output, 1, fault flag).
REQ-015 SHALL have port fault_cnt, output, 8 bits, saturating misalignment count.
REQ-016 SHALL have data-memory side outputs MemR (1), MemWr (1), MemWrBits (2: 00 sw, 01 sh, 10 sb), MemRBits (3), addr (32) and data (32).
REQ-017 SHALL have port ReadData, input, 32 bits, the combinational read data from memory.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCESS, RESP and FAULT; req_ready = 1 only in IDLE.
REQ-019 In IDLE, when req_valid is high, the unit SHALL latch we, size, signed, addr and wdata on the clock edge.
REQ-020 The alignment check SHALL be: word requires addr[1:0]=00; half requires addr[0]=0; byte is always aligned.
REQ-021 An aligned request SHALL go IDLE->ACCESS; a misaligned request SHALL go IDLE->FAULT and issue no memory access.
REQ-022 ACCESS SHALL last exactly one cycle: addr and data equal the latched values; MemWr = we; MemR = ~we.
REQ-023 In ACCESS, MemWrBits/MemRBits SHALL be decoded from size and signed using the parameter codes.
REQ-024 Outside ACCESS, MemR, MemWr, MemWrBits and MemRBits SHALL be 0; addr and data hold their last latched values.
REQ-025 A load SHALL capture ReadData into resp_rdata on the edge that ends ACCESS; a store SHALL set resp_rdata = 0.
REQ-026 The store write SHALL occur on that same edge, so MemWr is high for exactly one rising edge per store.
REQ-027 ACCESS SHALL go to RESP; FAULT SHALL assert resp_valid with resp_misalign = 1 and resp_rdata = 0.
REQ-028 In RESP/FAULT, resp_valid SHALL stay high with stable outputs until resp_ready; on the handshake the next state is IDLE and resp_valid drops.
REQ-029 Latency from acceptance edge N: resp_valid SHALL be high from cycle N+2 (aligned) or N+1 (misaligned); throughput is 1 request per 3 cycles with resp_ready held high.
REQ-030 On entering FAULT, fault_cnt SHALL increment by 1, saturating at 255.
REQ-031 A req_valid outside IDLE SHALL be ignored; the requester holds it until req_ready.

Reset
REQ-032 While rst_n = 0, state SHALL be IDLE and all outputs 0 except req_ready = 1, independent of clk.
REQ-033 Reset during ACCESS SHALL drop MemWr/MemR immediately and abort the access with no response.

Verification
REQ-034 sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> MemWr high for one cycle with MemWrBits = 00; the load returns resp_rdata = 0xDEADBEEF at N+2.
REQ-035 sb 0x13 data 0x80, then lb 0x13 / lbu 0x13 -> MemRBits = 100 / 011; resp_rdata = 0xFFFFFF80 / 0x00000080.
REQ-036 lh 0x12 with word = 0x8001xxxx -> resp_rdata = 0xFFFF8001; lhu -> 0x00008001.
REQ-037 lw 0x02 and sh 0x05 -> resp_misalign = 1 at N+1, no MemR/MemWr pulse, fault_cnt = 2; 300 faults -> fault_cnt = 255.
REQ-038 resp_ready held low 5 cycles -> resp_valid and resp_rdata stable and req_ready = 0 throughout; the next request is accepted the cycle after the handshake.
REQ-039 rst_n pulled low mid-ACCESS of sw -> MemWr falls combinationally, the target word is unchanged, state = IDLE and resp_valid = 0.
